// File: rtl/mem_port_arbiter.sv
// Purpose : shares one unified memory port between instruction fetch (IF) and the LSU, round-robin, one transaction in flight.
// Latency : grant at N, mem_req at N+1, response pulse one cycle after mem_ready is sampled (N+2 at best).
// Backpr. : requests are held by the requesters until their grant; memory stalls by holding mem_ready low.
//
// Ports:
//   clk, rst                        - core clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt        - fetch request, one-cycle grant pulse
//   if_rvalid/if_rdata              - fetch response pulse and held read data
//   lsu_req/we/addr/wdata/be        - load/store request, lsu_gnt one-cycle grant pulse
//   lsu_rvalid/lsu_rdata            - load data or store acknowledge pulse
//   mem_req/we/addr/wdata/be        - latched request towards memory, held until mem_ready
//   mem_ready/mem_rdata             - memory completion and read data
//   sel                             - port mux select, 1 = LSU path, 0 = IF path
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_be,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  sel
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_LSU = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_owner;   // 0 = IF, 1 = LSU
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BE_W-1:0]     r_mem_be;
    logic                r_sel;
    logic                r_if_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_lsu_rvalid;
    logic [DATA_W-1:0]   r_lsu_rdata;

    logic                w_idle;
    logic                w_gnt_if;
    logic                w_gnt_lsu;

    // On a tie the requester that did not own the port last wins, which
    // alternates strictly; last_owner resets to LSU so IF wins the first tie.
    assign w_idle    = (r_state == IDLE);
    assign w_gnt_if  = w_idle && if_req  && (!lsu_req || r_last_owner);
    assign w_gnt_lsu = w_idle && lsu_req && (!if_req  || !r_last_owner);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_sel        <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_rdata  <= '0;
        end else begin
            r_if_rvalid  <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // mem_ready is ignored here: nothing is outstanding
                    if (w_gnt_if) begin
                        r_state      <= BUSY_IF;
                        r_last_owner <= 1'b0;
                        r_sel        <= 1'b0;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_mem_be     <= {BE_W{1'b1}};
                    end else if (w_gnt_lsu) begin
                        r_state      <= BUSY_LSU;
                        r_last_owner <= 1'b1;
                        r_sel        <= 1'b1;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= lsu_we;
                        r_mem_addr   <= lsu_addr;
                        r_mem_wdata  <= lsu_wdata;
                        r_mem_be     <= lsu_be;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        r_state     <= IDLE;
                        r_mem_req   <= 1'b0;
                        r_if_rdata  <= mem_rdata;
                        r_if_rvalid <= 1'b1;
                    end
                end
                BUSY_LSU: begin
                    // For stores the captured data is meaningless; rvalid acts as the ack.
                    if (mem_ready) begin
                        r_state      <= IDLE;
                        r_mem_req    <= 1'b0;
                        r_lsu_rdata  <= mem_rdata;
                        r_lsu_rvalid <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt     = w_gnt_if;
    assign lsu_gnt    = w_gnt_lsu;
    assign if_rvalid  = r_if_rvalid;
    assign if_rdata   = r_if_rdata;
    assign lsu_rvalid = r_lsu_rvalid;
    assign lsu_rdata  = r_lsu_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign sel        = r_sel;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (IF) and load/store unit (LSU).
- Round-robin, one outstanding transaction at a time.
- Drives the select line of the port's 2:1 address/data muxes, latches request fields and returns the response to the owning requester.
- Sits between the fetch stage, the memory stage and the memory interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enable width is DATA_W/8.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  IF request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle grant pulse to IF.
- if_rvalid  out  1  one-cycle response valid to IF.
- if_rdata  out  DATA_W  fetched word; valid with if_rvalid.
- lsu_req  in  1  LSU request; held with its fields until lsu_gnt.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wdata  in  DATA_W  store data.
- lsu_be  in  DATA_W/8  byte enables.
- lsu_gnt  out  1  one-cycle grant pulse to LSU.
- lsu_rvalid  out  1  one-cycle load data valid, or store acknowledge.
- lsu_rdata  out  DATA_W  load data; valid with lsu_rvalid.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_be  out  DATA_W/8  latched byte enables; all ones for IF.
- mem_ready  in  1  memory accepts/completes the transfer this cycle.
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.
- sel  out  1  port mux select: 1 = LSU path, 0 = IF path.

Behaviour:
- States:
  - IDLE: no transaction.
  - BUSY_IF: IF transaction outstanding.
  - BUSY_LSU: LSU transaction outstanding.
- Internal register last_owner: 0 = IF, 1 = LSU.
- Reset values:
  - state = IDLE, last_owner = LSU.
  - mem_req, mem_we, sel, if_rvalid, lsu_rvalid = 0.
  - mem_addr, mem_wdata, if_rdata, lsu_rdata = 0; mem_be = 0.
- Arbitration, IDLE only; grants are combinational from IDLE state and the request inputs:
  - Only if_req: grant IF.
  - Only lsu_req: grant LSU.
  - Both: grant the requester that is not last_owner. This gives strict alternation, and IF wins the first tie after reset.
- On the grant edge:
  - x_gnt = 1 for exactly that cycle.
  - Request fields are latched into mem_addr, mem_we, mem_wdata and mem_be. IF latches mem_we=0 and mem_be all ones.
  - last_owner is updated; sel = 1 for LSU, 0 for IF.
  - mem_req goes to 1 next cycle; state moves to BUSY_x.
- BUSY_x:
  - mem_req stays 1 and mem_* stays stable until the cycle mem_ready=1 is sampled.
  - On that edge: mem_req goes to 0 and state returns to IDLE.
  - mem_rdata is captured into x_rdata and x_rvalid pulses for 1 cycle.
  - sel holds its value through the whole transaction and while in IDLE; it changes only on a grant.
- Latency: grant at cycle N; mem_req visible N+1; if mem_ready at N+1, x_rvalid at N+2 and a new grant is possible at N+2. Sustained throughput is 1 transaction per 2 cycles.
- Stores: lsu_rvalid is an acknowledge; lsu_rdata is don't-care.
- No grants while BUSY. Requests arriving during BUSY wait and are evaluated in IDLE.
- x_rdata holds its last value when x_rvalid=0.
- mem_ready while IDLE is ignored.
- Reset mid-transaction: next cycle mem_req=0, state=IDLE, no rvalid is issued and the transaction is dropped.
- Requester dropping req before gnt is legal; no grant is issued for it.

Test Plan:
- IF only:
  - Stimulus: if_addr=0x0000_0040, mem_ready tied 1, mem_rdata=0x0010_0093.
  - Required: if_gnt at N; mem_req/mem_addr=0x40/sel=0 at N+1; if_rvalid with if_rdata=0x0010_0093 at N+2.
- LSU store:
  - Stimulus: lsu_addr=0x1000, lsu_wdata=0xDEADBEEF, lsu_be=4'b0011, mem_ready delayed 3 cycles.
  - Required: mem_req high 3 cycles with mem_we=1, mem_be=4'b0011, sel=1; lsu_rvalid 1 cycle after mem_ready; no if_gnt meanwhile.
- Simultaneous requests after reset, both held for 4 transactions:
  - Required grant order IF, LSU, IF, LSU; sel toggles 0,1,0,1; each grant only in IDLE.
- Back-to-back IF reads, mem_ready=1:
  - Required: if_gnt every 2 cycles; addresses appear on mem_addr in order.
- Reset mid-transaction:
  - Stimulus: LSU load granted; rst asserted while mem_req=1 and mem_ready=0.
  - Required: next cycle mem_req=0, sel=0, no lsu_rvalid; the following IF request is granted normally.
- Requester withdrawal:
  - Stimulus: lsu_req pulses for 1 cycle while BUSY_IF.
  - Required: no lsu_gnt; mem_ready sampled in IDLE is ignored.
